dense_post: RTL
===============

DENSE_POST -- requirements
Module: dense_post

Interface
REQ-001 SHALL have parameter NUM_NEURONS, default 10, giving the number of neurons per frame (2..256).
REQ-002 SHALL have parameter SHIFT, default 8, giving the requantisation right-shift (1..24).
REQ-003 SHALL have port clk, input, 1 bit: the single clock; all logic is on its rising edge.
REQ-004 SHALL have port rst, input, 1 bit: synchronous active-low reset.
REQ-005 SHALL have port in_valid, input, 1 bit: an accumulator word is present.
REQ-006 SHALL have port in_ready, output, 1 bit: the block accepts a word this cycle.
REQ-007 SHALL have port in_acc, input, 32 bits: signed dense accumulator result.
REQ-008 SHALL have port in_bias, input, 32 bits: signed bias for the same neuron.
REQ-009 SHALL have port out_valid, output, 1 bit: out_data is valid.
REQ-010 SHALL have port out_ready, input, 1 bit: the downstream stage accepts out_data.
REQ-011 SHALL have port out_data, output, 8 bits: requantised activation, range 0..127.
REQ-012 SHALL have port out_last, output, 1 bit: out_data is the frame's final neuron.
REQ-013 SHALL have port class_valid, output, 1 bit: one-cycle pulse marking class_idx valid.
REQ-014 SHALL have port class_idx, output, clog2(NUM_NEURONS) bits: argmax neuron index.

Function
REQ-015 A transfer occurs on a cycle with in_valid=1 and in_ready=1; in_ready SHALL equal !out_valid || out_ready.
REQ-016 Latency SHALL be 1 cycle: an accepted word appears on out_data with out_valid=1 on the next cycle.
REQ-017 out_data, out_last and out_valid SHALL hold stable while out_valid=1 and out_ready=0.
REQ-018 The block SHALL compute sum = sext33(in_acc) + sext33(in_bias), with no overflow.
REQ-019 The block SHALL compute r = (sum + 2^(SHIFT-1)) >>> SHIFT (arithmetic shift, round-half-up).
REQ-020 out_data SHALL be 0 if r<0, 127 if r>127, else r[7:0].
REQ-021 A neuron counter SHALL increment per transfer and wrap to 0 after NUM_NEURONS-1; out_last=1 for the word accepted at count NUM_NEURONS-1.
REQ-022 The argmax SHALL compare the 33-bit sum (pre-shift, pre-saturation), and the first word of a frame SHALL load the running max unconditionally.
REQ-023 A later word SHALL replace the max only if strictly greater, so ties resolve to the lowest index.
REQ-024 class_valid SHALL pulse for exactly 1 cycle, the cycle after the last neuron is accepted; class_idx SHALL hold until the next pulse.
REQ-025 A new frame SHALL be accepted back-to-back with the previous one, with no idle cycle.

Reset
REQ-026 While rst=0 at a clock edge, the block SHALL set out_valid=0, out_data=0, out_last=0, class_valid=0, class_idx=0, neuron counter=0 and running max cleared.
REQ-027 A reset mid-frame SHALL discard the partial frame; the next accepted word is neuron 0.
REQ-028 in_ready SHALL be 1 in the first cycle after reset is released.

Configuration
REQ-029 With macro DENSE_POST_ARGMAX_EN defined, the argmax logic (REQ-022..024) SHALL be compiled in.
REQ-030 Without DENSE_POST_ARGMAX_EN, class_valid and class_idx SHALL be tied 0, and the datapath and out_last SHALL be unchanged.

Structure
REQ-031 A shared package dense_pkg SHALL hold ACC_W=32, ACT_W=8, ACT_MAX=127 and the requant rounding function.
REQ-032 A sub-module dense_argmax SHALL contain the running-max register, index register and comparator.

Verification (NUM_NEURONS=10, SHIFT=8)
REQ-033 in_acc=384, in_bias=0 -> out_data=2 after 1 cycle; in_acc=-1000, in_bias=0 -> out_data=0.
REQ-034 in_acc=0x00100000, in_bias=0 -> out_data=127; in_acc=0x7FFFFFFF, in_bias=0x7FFFFFFF -> out_data=127 (no wrap).
REQ-035 Frame of 10 words with in_acc=100*i, except i=7 with in_acc=5000 -> out_last on word 9, class_valid pulses once, class_idx=7.
REQ-036 Frame where neurons 3 and 5 share the maximum 4000 -> class_idx=3.
REQ-037 out_ready=0 for 2 cycles while out_valid=1 -> in_ready=0 and out_data held, then the transfer completes with no loss or duplication.
REQ-038 rst=0 after 4 words of a frame, then a fresh 10-word frame -> out_last on the 10th new word and class_idx taken from the new frame only.

Source files
------------

// File: rtl/dense_pkg.sv
// Shared widths and the requantisation helper for the dense post-processing block.
package dense_pkg;

    localparam int ACC_W   = 32;
    localparam int ACT_W   = 8;
    localparam int ACT_MAX = 127;
    localparam int SUM_W   = ACC_W + 1;

    // Round-half-up arithmetic shift, then clamp into 0..ACT_MAX.
    function automatic logic [ACT_W-1:0] requant(input logic signed [SUM_W-1:0] sum,
                                                 input int unsigned shift);
        logic signed [SUM_W:0] rnd;
        rnd = {sum[SUM_W-1], sum} + ({{SUM_W{1'b0}}, 1'b1} << (shift - 1));
        rnd = rnd >>> shift;
        if (rnd[SUM_W]) begin
            return '0;
        end else if (|rnd[SUM_W-1:ACT_W-1]) begin
            return ACT_W'(ACT_MAX);
        end
        return rnd[ACT_W-1:0];
    endfunction

endpackage

// File: rtl/dense_argmax.sv
// Running-max tracker over one frame of 33-bit sums; reports the winning index once per frame.
module dense_argmax
    import dense_pkg::*;
#(
    parameter int IDX_W = 4
) (
    input  logic                    clk_i,
    input  logic                    rst_ni,
    input  logic                    fire_i,
    input  logic                    first_i,
    input  logic                    last_i,
    input  logic [IDX_W-1:0]        idx_i,
    input  logic signed [SUM_W-1:0] sum_i,
    output logic                    class_valid_o,
    output logic [IDX_W-1:0]        class_idx_o
);

    logic signed [SUM_W-1:0] max_q, max_d;
    logic [IDX_W-1:0]        max_idx_q, max_idx_d;
    logic                    cv_q, cv_d;
    logic [IDX_W-1:0]        cidx_q, cidx_d;
    logic                    take;

    // Strict compare keeps the lowest index on ties.
    always_comb begin
        take      = first_i || (sum_i > max_q);
        max_d     = max_q;
        max_idx_d = max_idx_q;
        cv_d      = 1'b0;
        cidx_d    = cidx_q;
        if (fire_i) begin
            if (take) begin
                max_d     = sum_i;
                max_idx_d = idx_i;
            end
            if (last_i) begin
                cv_d   = 1'b1;
                cidx_d = take ? idx_i : max_idx_q;
            end
        end
    end

    always_ff @(posedge clk_i) begin
        if (!rst_ni) begin
            max_q     <= '0;
            max_idx_q <= '0;
            cv_q      <= 1'b0;
            cidx_q    <= '0;
        end else begin
            max_q     <= max_d;
            max_idx_q <= max_idx_d;
            cv_q      <= cv_d;
            cidx_q    <= cidx_d;
        end
    end

    assign class_valid_o = cv_q;
    assign class_idx_o   = cidx_q;

endmodule

// File: rtl/dense_post.sv
// Dense-layer post stage: bias add, requantise to 0..127, frame framing and optional argmax.
// Argmax is compiled in only when DENSE_POST_ARGMAX_EN is defined.
module dense_post
    import dense_pkg::*;
#(
    parameter int NUM_NEURONS = 10,
    parameter int SHIFT       = 8
) (
    input  logic                           clk,
    input  logic                           rst,
    input  logic                           in_valid,
    output logic                           in_ready,
    input  logic [ACC_W-1:0]               in_acc,
    input  logic [ACC_W-1:0]               in_bias,
    output logic                           out_valid,
    input  logic                           out_ready,
    output logic [ACT_W-1:0]               out_data,
    output logic                           out_last,
    output logic                           class_valid,
    output logic [$clog2(NUM_NEURONS)-1:0] class_idx
);

    localparam int IDX_W = $clog2(NUM_NEURONS);
    localparam logic [IDX_W-1:0] LAST_IDX = IDX_W'(NUM_NEURONS - 1);

    logic                    fire;
    logic                    is_last;
    logic signed [SUM_W-1:0] sum;
    logic [IDX_W-1:0]        cnt_q, cnt_d;
    logic                    out_valid_q, out_valid_d;
    logic [ACT_W-1:0]        out_data_q, out_data_d;
    logic                    out_last_q, out_last_d;

    assign in_ready = !out_valid_q || out_ready;
    assign fire     = in_valid && in_ready;
    assign sum      = $signed({in_acc[ACC_W-1], in_acc}) + $signed({in_bias[ACC_W-1], in_bias});
    assign is_last  = (cnt_q == LAST_IDX);

    always_comb begin
        cnt_d       = cnt_q;
        out_valid_d = out_valid_q;
        out_data_d  = out_data_q;
        out_last_d  = out_last_q;
        if (fire) begin
            out_valid_d = 1'b1;
            out_data_d  = requant(sum, SHIFT);
            out_last_d  = is_last;
            cnt_d       = is_last ? '0 : cnt_q + IDX_W'(1);
        end else if (out_ready) begin
            out_valid_d = 1'b0;
        end
    end

    always_ff @(posedge clk) begin
        if (!rst) begin
            cnt_q       <= '0;
            out_valid_q <= 1'b0;
            out_data_q  <= '0;
            out_last_q  <= 1'b0;
        end else begin
            cnt_q       <= cnt_d;
            out_valid_q <= out_valid_d;
            out_data_q  <= out_data_d;
            out_last_q  <= out_last_d;
        end
    end

    assign out_valid = out_valid_q;
    assign out_data  = out_data_q;
    assign out_last  = out_last_q;

`ifdef DENSE_POST_ARGMAX_EN
    dense_argmax #(
        .IDX_W(IDX_W)
    ) u_argmax (
        .clk_i        (clk),
        .rst_ni       (rst),
        .fire_i       (fire),
        .first_i      (cnt_q == '0),
        .last_i       (is_last),
        .idx_i        (cnt_q),
        .sum_i        (sum),
        .class_valid_o(class_valid),
        .class_idx_o  (class_idx)
    );
`else
    assign class_valid = 1'b0;
    assign class_idx   = '0;
`endif

endmodule
